// File: rtl/matricial_scanner.sv
`default_nettype none
// ============================================================================
// Module      : matricial_scanner
// Description : Keypad matrix scanner. Drives one column low at a time,
//               samples the synchronised rows into a frame, debounces whole
//               frames, turns debounced key changes into key-code events
//               (optional auto-repeat) and queues them in a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module matricial_scanner #(
    parameter int  N_LIN         = 4,
    parameter int  N_COL         = 4,
    parameter int  SCAN_CYCLES   = 50000,
    parameter int  DEBOUNCE      = 4,
    parameter int  FIFO_DEPTH    = 4,
    parameter int  REPEAT_EN     = 0,
    parameter int  REPEAT_FRAMES = 200,
    localparam int CW            = $clog2(N_LIN * N_COL)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [N_COL-1:0] matricial_col,
    input  logic [N_LIN-1:0] matricial_lin,
    output logic [CW-1:0]    key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_held,
    output logic             multi_key,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int c_nkeys = N_LIN * N_COL;
    localparam int c_dw    = $clog2(SCAN_CYCLES);
    localparam int c_ciw   = $clog2(N_COL);
    localparam int c_sw    = $clog2(DEBOUNCE + 1);
    localparam int c_rw    = $clog2(REPEAT_FRAMES + 1);
    localparam int c_aw    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_MULTI  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Row synchroniser and column scan
    // ------------------------------------------------------------------
    logic [N_LIN-1:0]   r_lin_meta;
    logic [N_LIN-1:0]   r_lin_sync;
    logic [c_dw-1:0]    r_dwell;
    logic [c_ciw-1:0]   r_col_idx;
    logic               w_last_dwell;
    logic               w_frame_end;

    // Two-flop synchroniser; idle rows read high (pull-ups)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lin_meta <= '1;
            r_lin_sync <= '1;
        end else begin
            r_lin_meta <= matricial_lin;
            r_lin_sync <= r_lin_meta;
        end
    end

    assign w_last_dwell = (r_dwell == c_dw'(SCAN_CYCLES - 1));
    assign w_frame_end  = w_last_dwell && (r_col_idx == c_ciw'(N_COL - 1));

    // Dwell counter and column index, wrapping after the last column
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dwell   <= '0;
            r_col_idx <= '0;
        end else if (w_last_dwell) begin
            r_dwell   <= '0;
            r_col_idx <= (r_col_idx == c_ciw'(N_COL - 1)) ? '0 : r_col_idx + 1'b1;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    // One-cold column drive decoded from the column index
    always_comb begin
        matricial_col = '1;
        for (int c = 0; c < N_COL; c++) begin
            if (c == int'(r_col_idx)) begin
                matricial_col[c] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame capture and debounce
    // ------------------------------------------------------------------
    logic [c_nkeys-1:0] r_raw;
    logic [c_nkeys-1:0] r_prev_raw;
    logic [c_nkeys-1:0] r_deb;
    logic [c_nkeys-1:0] w_frame;
    logic [c_sw-1:0]    r_stable;
    logic [c_sw-1:0]    w_stable_nxt;
    logic               r_deb_upd;

    // Current partial frame with the active column overlaid (1 = pressed)
    always_comb begin
        w_frame = r_raw;
        for (int l = 0; l < N_LIN; l++) begin
            for (int c = 0; c < N_COL; c++) begin
                if (c == int'(r_col_idx)) begin
                    w_frame[l*N_COL + c] = ~r_lin_sync[l];
                end
            end
        end
    end

    // Stable-frame count saturates at its load threshold, so a steady
    // matrix keeps producing one debounced update per frame
    always_comb begin
        w_stable_nxt = '0;
        if (w_frame == r_prev_raw) begin
            w_stable_nxt = (r_stable == c_sw'(DEBOUNCE - 1)) ? r_stable : r_stable + 1'b1;
        end
    end

    // Raw frame capture, stable count and debounced matrix load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_raw      <= '0;
            r_prev_raw <= '0;
            r_deb      <= '0;
            r_stable   <= '0;
            r_deb_upd  <= 1'b0;
        end else begin
            r_deb_upd <= 1'b0;
            if (w_last_dwell) begin
                r_raw <= w_frame;
            end
            if (w_frame_end) begin
                r_prev_raw <= w_frame;
                r_stable   <= w_stable_nxt;
                if (w_stable_nxt == c_sw'(DEBOUNCE - 1)) begin
                    r_deb     <= w_frame;
                    r_deb_upd <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounced matrix decode
    // ------------------------------------------------------------------
    logic          w_any;
    logic          w_multi;
    logic [CW-1:0] w_single_code;
    logic          r_key_held;
    logic          r_multi_key;

    // Key-count classification and lowest pressed key code
    always_comb begin
        w_any         = 1'b0;
        w_multi       = 1'b0;
        w_single_code = '0;
        for (int i = 0; i < c_nkeys; i++) begin
            w_multi = w_multi | (w_any & r_deb[i]);
            w_any   = w_any | r_deb[i];
        end
        for (int i = c_nkeys - 1; i >= 0; i--) begin
            if (r_deb[i]) begin
                w_single_code = CW'(i);
            end
        end
    end

    // Registered status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_held  <= 1'b0;
            r_multi_key <= 1'b0;
        end else begin
            r_key_held  <= w_any;
            r_multi_key <= w_multi;
        end
    end

    assign key_held  = r_key_held;
    assign multi_key = r_multi_key;

    // ------------------------------------------------------------------
    // Event FSM
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cur_key;
    logic [CW-1:0]   w_cur_key_nxt;
    logic [c_rw-1:0] r_rep_cnt;
    logic [c_rw-1:0] w_rep_cnt_nxt;
    logic            w_push;

    // State, held key and repeat counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cur_key <= '0;
            r_rep_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_key <= w_cur_key_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
        end
    end

    // Next state and push decision, evaluated once per debounced update
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_key_nxt = r_cur_key;
        w_rep_cnt_nxt = r_rep_cnt;
        w_push        = 1'b0;
        if (r_deb_upd) begin
            if (!w_any) begin
                w_state_nxt   = ST_IDLE;
                w_rep_cnt_nxt = '0;
            end else if (w_multi) begin
                w_state_nxt   = ST_MULTI;
                w_rep_cnt_nxt = '0;
            end else begin
                w_state_nxt   = ST_SINGLE;
                w_cur_key_nxt = w_single_code;
                case (r_state)
                    ST_IDLE: begin
                        w_push        = 1'b1;
                        w_rep_cnt_nxt = '0;
                    end
                    ST_SINGLE: begin
                        if (w_single_code != r_cur_key) begin
                            w_push        = 1'b1;
                            w_rep_cnt_nxt = '0;
                        end else if (REPEAT_EN != 0) begin
                            if (r_rep_cnt == c_rw'(REPEAT_FRAMES - 1)) begin
                                w_push        = 1'b1;
                                w_rep_cnt_nxt = '0;
                            end else begin
                                w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_rep_cnt_nxt = '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [CW-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    logic          r_overflow;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_drop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_pop     = !w_empty && key_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // Storage and pointers; a pop frees the slot a same-cycle push uses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[c_aw-1:0]] <= w_single_code;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps it set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign key_valid = !w_empty;
    assign key_code  = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_matricial_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_matricial_scanner
// Description : Directed self-checking bench for matricial_scanner with a
//               behavioural keypad model (pressed key shorts row to column).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matricial_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] lin;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       multi_key;
    logic       overflow;
    logic       clr_overflow;
    logic [15:0] keys;

    logic [3:0] col_r;
    logic [3:0] lin_r;
    logic [3:0] code_r;
    logic       valid_r;
    logic       ready_r;
    logic       held_r;
    logic       multi_r;
    logic       ovf_r;
    logic       clr_r;
    logic [15:0] keys_r;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] ev_q   [$];
    logic [3:0] ev_r_q [$];

    always #5 clk = ~clk;

    matricial_scanner #(
        .N_LIN(4), .N_COL(4), .SCAN_CYCLES(4), .DEBOUNCE(2),
        .FIFO_DEPTH(4), .REPEAT_EN(0), .REPEAT_FRAMES(3)
    ) dut (
        .clk(clk), .rst(rst), .matricial_col(col), .matricial_lin(lin),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .multi_key(multi_key), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    matricial_scanner #(
        .N_LIN(4), .N_COL(4), .SCAN_CYCLES(4), .DEBOUNCE(2),
        .FIFO_DEPTH(4), .REPEAT_EN(1), .REPEAT_FRAMES(3)
    ) dut_rep (
        .clk(clk), .rst(rst), .matricial_col(col_r), .matricial_lin(lin_r),
        .key_code(code_r), .key_valid(valid_r), .key_ready(ready_r),
        .key_held(held_r), .multi_key(multi_r), .overflow(ovf_r),
        .clr_overflow(clr_r)
    );

    // Keypad model: a pressed key pulls its row low while its column is driven
    always_comb begin
        lin   = '1;
        lin_r = '1;
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[l*4+c] && !col[c])     lin[l]   = 1'b0;
                if (keys_r[l*4+c] && !col_r[c]) lin_r[l] = 1'b0;
            end
        end
    end

    // Record every popped event
    always @(negedge clk) begin
        if (rst && key_valid && key_ready) ev_q.push_back(key_code);
        if (rst && valid_r && ready_r)     ev_r_q.push_back(code_r);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] ev_at(input int i);
        return (ev_q.size() > i) ? ev_q[i] : 4'hF;
    endfunction

    function automatic logic [3:0] ev_r_at(input int i);
        return (ev_r_q.size() > i) ? ev_r_q[i] : 4'hF;
    endfunction

    logic [3:0] codes036 [5];
    bit         found;

    initial begin
        codes036 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
        rst = 1'b0; keys = '0; keys_r = '0;
        key_ready = 1'b1; ready_r = 1'b1;
        clr_overflow = 1'b0; clr_r = 1'b0;
        cyc(2);
        chk("rst_valid",  key_valid, 0);
        chk("rst_code",   key_code,  0);
        chk("rst_col",    col,       4'b1110);
        chk("rst_held",   key_held,  0);
        chk("rst_multi",  multi_key, 0);
        chk("rst_ovf",    overflow,  0);
        rst = 1'b1;
        cyc(40);

        // Single press / release
        ev_q.delete();
        keys[9] = 1'b1;
        cyc(64);
        chk("t033_count", ev_q.size(), 1);
        chk("t033_code",  ev_at(0),    9);
        chk("t033_held",  key_held,    1);
        keys = '0;
        cyc(64);
        chk("t033_count_rel", ev_q.size(), 1);
        chk("t033_held_rel",  key_held,    0);

        // Bouncing contact then steady hold
        ev_q.delete();
        for (int i = 0; i < 12; i++) begin
            keys[3] = ~keys[3];
            cyc(5);
        end
        keys[3] = 1'b1;
        cyc(64);
        chk("t034_count", ev_q.size(), 1);
        chk("t034_code",  ev_at(0),    3);
        keys = '0;
        cyc(64);

        // Two keys together, partial release, fresh press
        ev_q.delete();
        keys[0] = 1'b1; keys[5] = 1'b1;
        cyc(64);
        chk("t035_multi", multi_key,   1);
        chk("t035_held",  key_held,    1);
        chk("t035_none",  ev_q.size(), 0);
        keys[5] = 1'b0;
        cyc(64);
        chk("t035_multi_rel", multi_key,   0);
        chk("t035_held_one",  key_held,    1);
        chk("t035_none_rel",  ev_q.size(), 0);
        keys = '0;
        cyc(64);
        chk("t035_idle", key_held, 0);
        keys[0] = 1'b1;
        cyc(64);
        chk("t035_count", ev_q.size(), 1);
        chk("t035_code",  ev_at(0),    0);
        keys = '0;
        cyc(64);

        // Overflow with a stalled consumer
        ev_q.delete();
        key_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            keys[codes036[i]] = 1'b1;
            cyc(64);
            keys = '0;
            cyc(64);
        end
        chk("t036_valid", key_valid, 1);
        chk("t036_head",  key_code,  1);
        chk("t036_ovf",   overflow,  1);
        key_ready = 1'b1;
        cyc(10);
        chk("t036_count", ev_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("t036_drain", ev_at(i), codes036[i]);
        chk("t036_empty",    key_valid, 0);
        chk("t036_ovf_kept", overflow,  1);
        clr_overflow = 1'b1;
        cyc(1);
        clr_overflow = 1'b0;
        chk("t036_ovf_clr", overflow, 0);

        // Auto-repeat on the second instance
        ev_r_q.delete();
        keys_r[7] = 1'b1;
        cyc(192);
        keys_r = '0;
        cyc(80);
        chk("t037_count", ev_r_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("t037_code", ev_r_at(i), 7);
        cyc(64);
        chk("t037_after", ev_r_q.size(), 4);
        chk("t037_held",  held_r,        0);
        chk("t037_ovf",   ovf_r,         0);

        // Reset in the middle of column 2 with events queued
        key_ready = 1'b0;
        keys[1] = 1'b1; cyc(64); keys = '0; cyc(64);
        keys[2] = 1'b1; cyc(64); keys = '0; cyc(64);
        chk("t038_queued", key_valid, 1);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (col == 4'b1011) found = 1'b1;
        end
        chk("t038_find", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("t038_valid", key_valid, 0);
        chk("t038_code",  key_code,  0);
        chk("t038_col",   col,       4'b1110);
        @(negedge clk);
        rst = 1'b1;
        cyc(3);
        chk("t038_col0", col,       4'b1110);
        chk("t038_drop", key_valid, 0);
        cyc(1);
        chk("t038_col1", col, 4'b1101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matricial_scanner.md
MATRICIAL_SCANNER -- requirements
Module: matricial_scanner

Interface
REQ-001 Parameter N_LIN, 4, keypad rows (2..8).
REQ-002 Parameter N_COL, 4, keypad columns (2..8).
REQ-003 Parameter SCAN_CYCLES, 50000, clk cycles each column is driven (>=4).
REQ-004 Parameter DEBOUNCE, 4, consecutive identical frames required to accept a matrix change (>=1).
REQ-005 Parameter FIFO_DEPTH, 4, key-event FIFO entries (power of 2, >=2).
REQ-006 Parameter REPEAT_EN, 0, 1 enables auto-repeat of a held single key.
REQ-007 Parameter REPEAT_FRAMES, 200, held-key frames between repeat events (>=1).
REQ-008 clk  input  1  single clock; all state on rising edge.
REQ-009 rst  input  1  asynchronous, active-low reset.
REQ-010 matricial_col  output  N_COL  column drive; active-low, one-cold.
REQ-011 matricial_lin  input  N_LIN  row sense; active-low (pull-ups), asynchronous to clk.
REQ-012 key_code  output  CW=$clog2(N_LIN*N_COL)  FIFO head code = lin*N_COL+col.
REQ-013 key_valid  output  1  FIFO non-empty.
REQ-014 key_ready  input  1  consumer pop; pop occurs when key_valid&&key_ready.
REQ-015 key_held  output  1  debounced matrix has >=1 key down.
REQ-016 multi_key  output  1  debounced matrix has >=2 keys down.
REQ-017 overflow  output  1  sticky: an event was dropped on a full FIFO.
REQ-018 clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-019 matricial_lin SHALL pass a 2-flop synchronizer before any use.
REQ-020 Column index SHALL advance every SCAN_CYCLES cycles, wrapping N_COL-1 -> 0; only the indexed column bit is 0.
REQ-021 Synchronized rows SHALL be sampled on the last dwell cycle of each column into a raw N_LIN*N_COL frame; a frame completes after column N_COL-1.
REQ-022 At frame end, raw==previous raw increments stable count (saturating), else count clears; debounced matrix SHALL load raw when count reaches DEBOUNCE-1 (DEBOUNCE=1: every frame).
REQ-023 Event FSM on debounced matrix: IDLE (0 keys), SINGLE (1 key), MULTI (>=2 keys); evaluated once per debounced update.
REQ-024 IDLE->SINGLE SHALL push that key's code; IDLE->MULTI pushes nothing.
REQ-025 SINGLE->MULTI and MULTI->SINGLE push nothing; any state ->IDLE on 0 keys; SINGLE to a different single key (no IDLE between) pushes the new code.
REQ-026 REPEAT_EN=1: in SINGLE, a push of the held code SHALL occur every REPEAT_FRAMES frames after entry; repeat counter clears on any state change.
REQ-027 FIFO order SHALL be first-in-first-out; key_code valid whenever key_valid=1, stable until popped.
REQ-028 Push on full with no pop SHALL drop the new code and set overflow; push and pop in same cycle on full both succeed.
REQ-029 clr_overflow SHALL clear overflow next cycle; a simultaneous drop wins (overflow stays 1).
REQ-030 key_held/multi_key SHALL be registered decodes of the debounced matrix.

Reset
REQ-031 rst=0 SHALL immediately force: column index 0 (matricial_col = all ones except bit0=0), FIFO empty, key_valid=0, key_code=0, key_held=0, multi_key=0, overflow=0, FSM IDLE, all counters and matrices 0.
REQ-032 Reset mid-frame SHALL discard partial frames and queued events; scanning restarts at column 0 on first clk after release.

Verification (N_LIN=N_COL=4, SCAN_CYCLES=4, DEBOUNCE=2, FIFO_DEPTH=4; frame=16 cycles)
REQ-033 Hold lin2/col1 pressed, key_ready=1 -> one key_valid pulse with key_code=9 within 64 cycles; release -> no further events, key_held returns 0.
REQ-034 Toggle lin0 under col3 every 5 cycles for 60 cycles then hold -> exactly one event, code 3.
REQ-035 Press codes 0 and 5 together -> multi_key=1, no event; release 5 with 0 held -> no event; release all, press 0 -> event code 0.
REQ-036 key_ready=0, five distinct press/release cycles codes 1,2,3,4,6 -> overflow=1, drain yields 1,2,3,4; clr_overflow -> overflow=0.
REQ-037 REPEAT_EN=1, REPEAT_FRAMES=3, hold code 7 for 12 frames -> events at entry then every 3 frames (code 7 each), none after release.
REQ-038 Assert rst=0 mid-dwell of col2 with 2 codes queued -> same-cycle key_valid=0, matricial_col=4'b1110; release -> normal scan resumes at col0.
